// File: rtl/pipe_pkg.sv
// Shared ID/EX payload layout, control-bit indices and NOP constant.
package pipe_pkg;

    localparam int ID_D_SIZE  = 32;
    localparam int ID_AD_SIZE = 32;
    localparam int ID_REG_AW  = 5;
    localparam int ID_FUNCT_W = 6;
    localparam int CTRL_W     = 5;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_BRANCH   = 4;

    typedef struct packed {
        logic [ID_D_SIZE-1:0]  in1;
        logic [ID_D_SIZE-1:0]  in2;
        logic [ID_D_SIZE-1:0]  store;
        logic [ID_REG_AW-1:0]  rs;
        logic [ID_REG_AW-1:0]  rt;
        logic [ID_REG_AW-1:0]  rd;
        logic [ID_REG_AW-1:0]  shamt;
        logic [ID_FUNCT_W-1:0] funct;
        logic [ID_AD_SIZE-1:0] addr;
        logic [CTRL_W-1:0]     ctrl;
    } id_ex_beat_t;

    localparam int BEAT_W = $bits(id_ex_beat_t);

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-slot skid buffer: main slot drives the output, skid slot
// absorbs one beat under backpressure. Ready is a pure register output.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         m_valid_q, m_valid_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] m_data_q, m_data_d;
    logic [W-1:0] s_data_q, s_data_d;
    logic         accept;
    logic         drain;

    assign ready_o = !s_valid_q;
    assign valid_o = m_valid_q;
    assign data_o  = m_data_q;

    assign accept = valid_i && !s_valid_q;
    assign drain  = m_valid_q && ready_i;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (drain && s_valid_q) begin
            m_data_d  = s_data_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
        end else if (drain || !m_valid_q) begin
            m_valid_d = accept;
            if (accept) m_data_d = data_i;
        end else if (accept) begin
            // Main slot is stalled: park the newer beat behind it.
            s_data_d  = data_i;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// Elastic ID/EX pipeline register with skid buffer, flush and bubble gating.
// Define ID_EX_PERF_EN to add stall_cnt / flush_cnt performance counters.
module id_ex_skid_reg #(
    parameter int D_SIZE  = pipe_pkg::ID_D_SIZE,
    parameter int AD_SIZE = pipe_pkg::ID_AD_SIZE,
    parameter int REG_AW  = pipe_pkg::ID_REG_AW,
    parameter int CTRL_W  = pipe_pkg::CTRL_W,
    parameter int FUNCT_W = pipe_pkg::ID_FUNCT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [D_SIZE-1:0]  rf_in1,
    input  logic [D_SIZE-1:0]  rf_in2,
    input  logic [D_SIZE-1:0]  rf_store,
    input  logic [REG_AW-1:0]  rf_rs,
    input  logic [REG_AW-1:0]  rf_rt,
    input  logic [REG_AW-1:0]  rf_rd,
    input  logic [REG_AW-1:0]  rf_shamt,
    input  logic [FUNCT_W-1:0] rf_funct,
    input  logic [AD_SIZE-1:0] se_address,
    input  logic [CTRL_W-1:0]  rf_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_SIZE-1:0]  alu_in1,
    output logic [D_SIZE-1:0]  alu_in2,
    output logic [D_SIZE-1:0]  alu_store,
    output logic [REG_AW-1:0]  alu_rs,
    output logic [REG_AW-1:0]  alu_rt,
    output logic [REG_AW-1:0]  alu_rd,
    output logic [REG_AW-1:0]  alu_shamt,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic [AD_SIZE-1:0] br_address,
    output logic [CTRL_W-1:0]  alu_ctrl
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    import pipe_pkg::*;

    localparam int PAYLOAD_W = 3*D_SIZE + 4*REG_AW + FUNCT_W + AD_SIZE + CTRL_W;

    logic [PAYLOAD_W-1:0] beat_in;
    logic [PAYLOAD_W-1:0] beat_out;
    logic [CTRL_W-1:0]    ctrl_raw;

    // Field order matches id_ex_beat_t so default builds share one layout.
    assign beat_in = {rf_in1, rf_in2, rf_store,
                      rf_rs, rf_rt, rf_rd, rf_shamt,
                      rf_funct, se_address, rf_ctrl};

    pipe_skid_buf #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .data_i  (beat_in),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (beat_out)
    );

    assign {alu_in1, alu_in2, alu_store,
            alu_rs, alu_rt, alu_rd, alu_shamt,
            alu_funct, br_address, ctrl_raw} = beat_out;

    // Empty stage presents a NOP so stale control never reaches EX.
    assign alu_ctrl = out_valid ? ctrl_raw : CTRL_W'(CTRL_NOP);

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && (out_valid || !in_ready)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Elastic ID/EX pipeline register between the register-file/decode stage and the ALU stage.
- Generalises the plain ID/EX latch: parametrised operand, address and control widths, a valid/ready handshake, a 2-entry skid buffer for full-throughput stalls, synchronous flush, and bubble insertion.
- Carries operands, the store-data word, register specifiers for hazard logic, shamt/funct, the sign-extended immediate/branch offset, and a packed control vector.

Parameters:
- D_SIZE, 32, width of operand and store-data words
- AD_SIZE, 32, width of the sign-extended immediate/branch address
- REG_AW, 5, register-specifier width (rs/rt/rd/shamt)
- CTRL_W, 5, control vector width; bit order {branch, memread, mem_write, memtoreg, regwrite}, LSB = regwrite
- FUNCT_W, 6, funct field width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decode stage presents a beat
- in_ready  out  1  stage can accept a beat
- flush  in  1  synchronous squash (branch taken / exception)
- rf_in1, rf_in2  in  D_SIZE  register-file operands
- rf_store  in  D_SIZE  store-data word for sw
- rf_rs, rf_rt, rf_rd, rf_shamt  in  REG_AW  specifiers
- rf_funct  in  FUNCT_W  function field
- se_address  in  AD_SIZE  sign-extended immediate
- rf_ctrl  in  CTRL_W  control vector
- out_valid  out  1  ALU-side beat valid
- out_ready  in  1  ALU stage accepts the beat
- alu_in1, alu_in2, alu_store  out  D_SIZE  registered operands and store data
- alu_rs, alu_rt, alu_rd, alu_shamt  out  REG_AW  registered specifiers
- alu_funct  out  FUNCT_W  registered funct
- br_address  out  AD_SIZE  registered immediate
- alu_ctrl  out  CTRL_W  registered control vector, gated by out_valid

Behaviour:
- Storage: main slot M (drives outputs) and skid slot S; each has a valid bit.
- in_ready = !S.valid, from a register only; there is no combinational path from out_ready.
- Accept condition: in_valid && in_ready. Drain condition: out_valid && out_ready. out_valid = M.valid.
- Per clock edge, priority order:
  - flush: M.valid and S.valid clear; a beat accepted in the same cycle is discarded; M/S data is not required to change.
  - drain and S.valid: S moves to M; S.valid clears; an accept is impossible (in_ready = 0).
  - drain or !M.valid: an accepted beat loads into M; with no accept, M.valid clears.
  - M.valid && !out_ready: an accepted beat loads into S.
- Latency: 1 cycle from accept to out_valid with the pipe empty. Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure: one extra beat is absorbed in S; in_ready falls on the following cycle.
- Ordering is strictly FIFO: S is never bypassed by a newer beat.
- Bubble: alu_ctrl = 0 whenever out_valid = 0, so downstream sees a NOP. Data outputs hold their last value.
- Reset (rst low, asynchronous): M.valid = S.valid = 0, out_valid = 0, alu_ctrl = 0, all data outputs 0, in_ready = 1. Reset asserted mid-stall drops both slots.
- flush and rst together: rst wins.
- flush while out_ready = 0: the held beat is dropped and in_ready returns to 1 on the next cycle.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - adds outputs stall_cnt (32) and flush_cnt (16), both cleared by rst.
  - stall_cnt increments each cycle with in_valid && !in_ready.
  - flush_cnt increments each cycle flush = 1 while M.valid or S.valid is set.
  - Both wrap modulo 2^width.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - CTRL_W and the control-bit index constants (CTRL_REGWRITE = 0 … CTRL_BRANCH = 4)
  - a packed id_ex_beat_t struct for the full payload
  - the NOP control constant (all zero)
- Sub-module pipe_skid_buf: a generic 2-slot skid buffer over an opaque payload of width $bits(id_ex_beat_t), instantiated once. The top level packs and unpacks the fields and applies control gating.

Test Plan:
- Reset: release rst; in_valid = 0 → out_valid = 0, alu_ctrl = 0, in_ready = 1; all outputs 0.
- Streaming: 4 beats on consecutive cycles with rf_in1 = 1, 2, 3, 4 and out_ready = 1 → out_valid from cycle+1; alu_in1 = 1, 2, 3, 4 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready = 0 after beat A is in M, send B and C → B is captured in S; in_ready = 0 the next cycle; C is held by the source. Raise out_ready → order A, B, C with no loss or duplication.
- Flush during stall: A in M, B in S, flush = 1 with in_valid = 1 (beat D) → next cycle out_valid = 0, alu_ctrl = 0, in_ready = 1, and D never appears.
- Bubble gating: rf_ctrl = 5'b00101 for one beat followed by an idle cycle → alu_ctrl = 5'b00101, then 5'b00000 while alu_in1 holds.
- Perf (ID_EX_PERF_EN): 3 stall cycles and 1 flush of an occupied stage → stall_cnt = 3, flush_cnt = 1.
